// File: rtl/boot_copy_init.sv
// boot_copy_init: start-up copier moving 64-bit words from a boot ROM port to a RAM port, one request at a time.
// Optional build macro BOOT_COPY_CHECKSUM_EN adds a running XOR of the words read on the checksum port.
package boot_copy_pkg;
    localparam int MEM_ADDR_W = 32;

    typedef struct packed {
        logic                  mem_valid;
        logic                  mem_instr;
        logic [MEM_ADDR_W-1:0] mem_addr;
        logic [63:0]           mem_wdata;
        logic [7:0]            mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic [63:0] mem_rdata;
        logic        mem_ready;
        logic        mem_error;
    } mem_out_type;
endpackage

module boot_copy_init
    import boot_copy_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [MEM_ADDR_W-1:0] src_base,
    input  logic [MEM_ADDR_W-1:0] dst_base,
    input  logic [CNT_W-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [MEM_ADDR_W-1:0] err_addr,
    output logic [63:0]           checksum,
    output mem_in_type            src_in,
    input  mem_out_type           src_out,
    output mem_in_type            dst_in,
    input  mem_out_type           dst_out
);

    localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        ERR
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [MEM_ADDR_W-1:0] src_q;
    logic [MEM_ADDR_W-1:0] dst_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      idx_q;
    logic [63:0]           data_q;
    logic [TMR_W-1:0]      timer_q;
    logic                  err_q;
    logic [MEM_ADDR_W-1:0] err_addr_q;
    logic                  zero_done_q;

    logic                  accept;
    logic                  last_word;
    logic                  timed_out;
    logic [MEM_ADDR_W-1:0] rd_addr;
    logic [MEM_ADDR_W-1:0] wr_addr;
    logic                  set_err;
    logic [MEM_ADDR_W-1:0] err_addr_nxt;
    logic                  capture;
    logic                  advance;
    logic                  copy_done;
    logic                  unused_dst_rdata;

    assign accept    = start && ((state == IDLE) || (state == ERR));
    assign last_word = (idx_q == (cnt_q - CNT_W'(1)));
    assign timed_out = (timer_q == TMR_W'(TIMEOUT - 1));
    assign rd_addr   = src_q + (MEM_ADDR_W'(idx_q) << 3);
    assign wr_addr   = dst_q + (MEM_ADDR_W'(idx_q) << 3);

    assign done     = copy_done | zero_done_q;
    assign error    = err_q;
    assign err_addr = err_addr_q;

    assign unused_dst_rdata = ^dst_out.mem_rdata;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        busy         = 1'b0;
        src_in       = '0;
        dst_in       = '0;
        set_err      = 1'b0;
        err_addr_nxt = '0;
        capture      = 1'b0;
        advance      = 1'b0;
        copy_done    = 1'b0;
        case (state)
            IDLE, ERR: begin
                if (start) begin
                    next_state = (count != '0) ? RD_REQ : IDLE;
                end
            end
            RD_REQ: begin
                busy             = 1'b1;
                src_in.mem_valid = 1'b1;
                src_in.mem_addr  = rd_addr;
                next_state       = RD_WAIT;
            end
            RD_WAIT: begin
                busy = 1'b1;
                if (src_out.mem_ready) begin
                    if (src_out.mem_error) begin
                        set_err      = 1'b1;
                        err_addr_nxt = rd_addr;
                        next_state   = ERR;
                    end else begin
                        capture    = 1'b1;
                        next_state = WR_REQ;
                    end
                end else if (timed_out) begin
                    set_err      = 1'b1;
                    err_addr_nxt = rd_addr;
                    next_state   = ERR;
                end
            end
            WR_REQ: begin
                busy             = 1'b1;
                dst_in.mem_valid = 1'b1;
                dst_in.mem_addr  = wr_addr;
                dst_in.mem_wdata = data_q;
                dst_in.mem_wstrb = 8'hFF;
                next_state       = WR_WAIT;
            end
            WR_WAIT: begin
                busy = 1'b1;
                if (dst_out.mem_ready) begin
                    if (dst_out.mem_error) begin
                        set_err      = 1'b1;
                        err_addr_nxt = wr_addr;
                        next_state   = ERR;
                    end else if (last_word) begin
                        copy_done  = 1'b1;
                        next_state = IDLE;
                    end else begin
                        advance    = 1'b1;
                        next_state = RD_REQ;
                    end
                end else if (timed_out) begin
                    set_err      = 1'b1;
                    err_addr_nxt = wr_addr;
                    next_state   = ERR;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The wait timer only runs inside a wait state, so it is zero on every entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            src_q       <= '0;
            dst_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            timer_q     <= '0;
            err_q       <= 1'b0;
            err_addr_q  <= '0;
            zero_done_q <= 1'b0;
        end else begin
            zero_done_q <= accept && (count == '0);
            if (accept) begin
                src_q <= src_base;
                dst_q <= dst_base;
                cnt_q <= count;
                idx_q <= '0;
                err_q <= 1'b0;
            end
            if (capture) begin
                data_q <= src_out.mem_rdata;
            end
            if (advance) begin
                idx_q <= idx_q + CNT_W'(1);
            end
            if (set_err) begin
                err_q      <= 1'b1;
                err_addr_q <= err_addr_nxt;
            end
            if ((state == RD_WAIT) || (state == WR_WAIT)) begin
                timer_q <= timer_q + TMR_W'(1);
            end else begin
                timer_q <= '0;
            end
        end
    end

`ifdef BOOT_COPY_CHECKSUM_EN
    logic [63:0] checksum_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            checksum_q <= '0;
        end else if (accept) begin
            checksum_q <= '0;
        end else if (capture) begin
            checksum_q <= checksum_q ^ src_out.mem_rdata;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 64'h0;
`endif

endmodule

// File: tb/tb_boot_copy_init.sv
// Self-checking bench for boot_copy_init: modelled ROM/RAM responders plus a request scoreboard.
module tb_boot_copy_init;
    import boot_copy_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
    } wr_t;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] src_base;
    logic [31:0] dst_base;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] err_addr;
    logic [63:0] checksum;
    mem_in_type  src_in;
    mem_out_type src_out;
    mem_in_type  dst_in;
    mem_out_type dst_out;

    logic        src_hang;
    logic        dst_err_en;
    logic [31:0] dst_err_addr;
    logic        prev_src_valid;
    logic        prev_dst_valid;

    logic [31:0] rd_q[$];
    wr_t         wr_q[$];
    logic [63:0] exp_sum;
    int          cyc = 0;
    int          start_cyc;
    int          seen;
    int          assert_count = 0;
    int          fail_count = 0;

    boot_copy_init #(
        .CNT_W  (16),
        .TIMEOUT(255)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .src_base(src_base),
        .dst_base(dst_base),
        .count   (count),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .err_addr(err_addr),
        .checksum(checksum),
        .src_in  (src_in),
        .src_out (src_out),
        .dst_in  (dst_in),
        .dst_out (dst_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [63:0] rom_word(input logic [31:0] a);
        return {a ^ 32'hB007_C0DE, ~a + 32'h0000_1357};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Responders answer one cycle after a request; hang and error injection are test knobs.
    always @(posedge clock) begin
        src_out.mem_ready <= src_in.mem_valid && !src_hang;
        src_out.mem_rdata <= rom_word(src_in.mem_addr);
        src_out.mem_error <= 1'b0;
        dst_out.mem_ready <= dst_in.mem_valid;
        dst_out.mem_error <= dst_in.mem_valid && dst_err_en && (dst_in.mem_addr == dst_err_addr);
        dst_out.mem_rdata <= '0;
    end

    always @(negedge clock) begin
        wr_t e;
        logic [31:0] a;
        if (src_in.mem_valid) begin
            checkOutput("rd_expected", rd_q.size() != 0, 1);
            checkOutput("src_valid_b2b", prev_src_valid, 0);
            checkOutput("rd_wstrb", src_in.mem_wstrb, 8'h00);
            if (rd_q.size() != 0) begin
                a = rd_q.pop_front();
                checkOutput("rd_addr", src_in.mem_addr, a);
            end
        end
        if (dst_in.mem_valid) begin
            checkOutput("wr_expected", wr_q.size() != 0, 1);
            checkOutput("dst_valid_b2b", prev_dst_valid, 0);
            checkOutput("wr_wstrb", dst_in.mem_wstrb, 8'hFF);
            if (wr_q.size() != 0) begin
                e = wr_q.pop_front();
                checkOutput("wr_addr", dst_in.mem_addr, e.addr);
                checkOutput("wr_data", dst_in.mem_wdata, e.data);
            end
        end
        prev_src_valid <= src_in.mem_valid;
        prev_dst_valid <= dst_in.mem_valid;
    end

    task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] cnt,
                                 input int n_rd, input int n_wr);
        for (int i = 0; i < n_rd; i++) rd_q.push_back(src + 32'(8 * i));
        exp_sum = '0;
        for (int i = 0; i < n_wr; i++) begin
            wr_q.push_back('{addr: dst + 32'(8 * i), data: rom_word(src + 32'(8 * i))});
            exp_sum ^= rom_word(src + 32'(8 * i));
        end
`ifndef BOOT_COPY_CHECKSUM_EN
        exp_sum = '0;
`endif
        @(posedge clock);
        #1;
        start     = 1'b1;
        src_base  = src;
        dst_base  = dst;
        count     = cnt;
        start_cyc = cyc;
        @(posedge clock);
        #1;
        start = 1'b0;
        checkOutput("busy_after_start", busy, cnt != 0);
        checkOutput("error_cleared", error, 0);
    endtask

    task automatic wait_event(input bit want_err, input int budget, output int seen_cyc);
        logic hit;
        hit      = 1'b0;
        seen_cyc = -1;
        for (int k = 0; k < budget && !hit; k++) begin
            @(negedge clock);
            if ((want_err ? error : done) === 1'b1) begin
                hit      = 1'b1;
                seen_cyc = cyc;
            end
        end
        checkOutput(want_err ? "error_wait" : "done_wait", hit, 1);
    endtask

    task automatic check_copy(input string tag, input int words);
        wait_event(1'b0, 4 * words + 20, seen);
        checkOutput({tag, "_done_latency"}, 64'(seen - start_cyc), words == 0 ? 1 : 4 * words);
        checkOutput({tag, "_busy_at_done"}, busy, 0 + (words != 0));
        @(negedge clock);
        checkOutput({tag, "_done_pulse"}, done, 0);
        checkOutput({tag, "_busy_after"}, busy, 0);
        checkOutput({tag, "_error"}, error, 0);
        checkOutput({tag, "_checksum"}, checksum, exp_sum);
        checkOutput({tag, "_rd_q_empty"}, rd_q.size(), 0);
        checkOutput({tag, "_wr_q_empty"}, wr_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0; start = 1'b0; src_base = '0; dst_base = '0; count = '0;
        src_hang = 1'b0; dst_err_en = 1'b0; dst_err_addr = '0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_err_addr", err_addr, 0);
        checkOutput("rst_checksum", checksum, 0);
        checkOutput("rst_src_in", |src_in, 0);
        checkOutput("rst_dst_in", |dst_in, 0);
        reset = 1'b1;

        $display("[TB] three-word copy");
        applyStimulus(32'h0, 32'h8000, 16'd3, 3, 3);
        check_copy("t1", 3);

        $display("[TB] zero-length copy");
        applyStimulus(32'h40, 32'h9000, 16'd0, 0, 0);
        check_copy("t2", 0);

        $display("[TB] source address wrap");
        applyStimulus(32'hFFFF_FFF8, 32'h0000_0040, 16'd2, 2, 2);
        check_copy("t3", 2);

        $display("[TB] destination error on second word, then restart");
        dst_err_en   = 1'b1;
        dst_err_addr = 32'h8008;
        applyStimulus(32'h100, 32'h8000, 16'd4, 2, 2);
        wait_event(1'b1, 60, seen);
        checkOutput("t4_err_latency", 64'(seen - start_cyc), 9);
        checkOutput("t4_err_addr", err_addr, 32'h8008);
        checkOutput("t4_busy", busy, 0);
        checkOutput("t4_checksum", checksum, exp_sum);
        repeat (10) @(negedge clock);
        checkOutput("t4_error_sticky", error, 1);
        checkOutput("t4_rd_q_empty", rd_q.size(), 0);
        checkOutput("t4_wr_q_empty", wr_q.size(), 0);
        dst_err_en = 1'b0;
        applyStimulus(32'h100, 32'h8000, 16'd4, 4, 4);
        check_copy("t4r", 4);

        $display("[TB] source timeout");
        src_hang = 1'b1;
        applyStimulus(32'h2000, 32'h3000, 16'd1, 1, 0);
        wait_event(1'b1, 400, seen);
        checkOutput("t5_err_latency", 64'(seen - start_cyc), 257);
        checkOutput("t5_err_addr", err_addr, 32'h2000);
        checkOutput("t5_busy", busy, 0);
        src_hang = 1'b0;
        repeat (3) @(negedge clock);

        $display("[TB] reset during first write wait");
        applyStimulus(32'h300, 32'h9000, 16'd3, 1, 1);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_done", done, 0);
        checkOutput("t6_error", error, 0);
        checkOutput("t6_err_addr", err_addr, 0);
        checkOutput("t6_checksum", checksum, 0);
        checkOutput("t6_src_in", |src_in, 0);
        checkOutput("t6_dst_in", |dst_in, 0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (10) @(negedge clock);
        checkOutput("t6_idle_busy", busy, 0);
        checkOutput("t6_rd_q_empty", rd_q.size(), 0);
        checkOutput("t6_wr_q_empty", wr_q.size(), 0);

        $display("[TB] start while busy is ignored");
        applyStimulus(32'h500, 32'hA000, 16'd2, 2, 2);
        @(posedge clock);
        #1;
        start    = 1'b1;
        src_base = 32'hF000;
        dst_base = 32'hF800;
        count    = 16'd5;
        @(posedge clock);
        #1;
        start = 1'b0;
        check_copy("t7", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
